// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
// Build option: ARB_RR_EN selects round-robin refill arbitration (see top).
package mem_req_arbiter_pkg;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  // Burst beat size used for all line transfers (4-byte beats).
  localparam logic [1:0] LINE_SIZE = 2'd2;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_DC_WB,
    ARB_DC_UW,
    ARB_DC_UR,
    ARB_DC_RD,
    ARB_IC_RD
  } arb_state_t;

  // Bit positions in the request / mask vectors.
  localparam int M_IC  = 0;
  localparam int M_DCR = 1;
  localparam int M_DCW = 2;
  localparam int M_UR  = 3;
  localparam int M_UW  = 4;

  // Number of byte-offset bits inside one cache line.
  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache/bridge signal bundle for the memory request arbiter.
// slave = arbiter side, master = caches + bridge side.
interface mem_req_arbiter_if
  import mem_req_arbiter_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              ic_rreq_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_rend_o;
  logic [LINE_W-1:0] ic_line_o;

  logic              dc_ca_rreq_i;
  logic              dc_ca_wreq_i;
  logic              dc_uc_rreq_i;
  logic              dc_uc_wreq_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [3:0]        dc_wen_i;
  logic [31:0]       dc_wdata_i;
  logic [1:0]        dc_size_i;
  logic [LINE_W-1:0] dc_line_i;
  logic              dc_rend_o;
  logic              dc_wend_o;
  logic [LINE_W-1:0] dc_line_o;

  logic              br_rreq_o;
  logic              br_rline_o;
  logic [ADDR_W-1:0] br_raddr_o;
  logic [1:0]        br_rsize_o;
  logic              br_rend_i;
  logic [LINE_W-1:0] br_rdata_i;
  logic              br_wreq_o;
  logic              br_wline_o;
  logic [ADDR_W-1:0] br_waddr_o;
  logic [LINE_W-1:0] br_wdata_o;
  logic [3:0]        br_wstrb_o;
  logic [1:0]        br_wsize_o;
  logic              br_wend_i;

  modport slave (
    input  ic_rreq_i, ic_addr_i,
    output ic_rend_o, ic_line_o,
    input  dc_ca_rreq_i, dc_ca_wreq_i, dc_uc_rreq_i, dc_uc_wreq_i,
    input  dc_addr_i, dc_wen_i, dc_wdata_i, dc_size_i, dc_line_i,
    output dc_rend_o, dc_wend_o, dc_line_o,
    output br_rreq_o, br_rline_o, br_raddr_o, br_rsize_o,
    input  br_rend_i, br_rdata_i,
    output br_wreq_o, br_wline_o, br_waddr_o, br_wdata_o, br_wstrb_o, br_wsize_o,
    input  br_wend_i
  );

  modport master (
    output ic_rreq_i, ic_addr_i,
    input  ic_rend_o, ic_line_o,
    output dc_ca_rreq_i, dc_ca_wreq_i, dc_uc_rreq_i, dc_uc_wreq_i,
    output dc_addr_i, dc_wen_i, dc_wdata_i, dc_size_i, dc_line_i,
    input  dc_rend_o, dc_wend_o, dc_line_o,
    input  br_rreq_o, br_rline_o, br_raddr_o, br_rsize_o,
    output br_rend_i, br_rdata_i,
    input  br_wreq_o, br_wline_o, br_waddr_o, br_wdata_o, br_wstrb_o, br_wsize_o,
    output br_wend_i
  );

endinterface

// File: rtl/mem_req_arbiter_rr.sv
// mem_arb_rr: 2-way round-robin picker. Slot 0 = icache, slot 1 = dcache.
// The pointer favours slot 0 out of reset and moves to the other slot
// after every advance.
module mem_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
  logic r_ptr;  // 0: slot 0 wins a tie, 1: slot 1 wins a tie

  // Grant: single requester wins outright, ties go to the pointer.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_ptr ? 2'b10 : 2'b01;
  end

  // Pointer: after a grant, favour the slot that was not served.
  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= 1'b0;
    else if (i_advance) r_ptr <= o_gnt[0];
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serialises icache refills and dcache traffic onto one
// bridge port, one transaction outstanding at a time.
// Build option: define ARB_RR_EN for round-robin dcache/icache refill
// arbitration; otherwise dcache refills have fixed priority over icache.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic             clk,
  input logic             rst,
  mem_req_arbiter_if.slave bus
);
  localparam int OFF_W = off_bits(LINE_W);

  arb_state_t r_state, w_nxt;
  logic [4:0] r_mask, w_req, w_own;
  logic [1:0] w_rf_req, w_rf_gnt;
  logic       w_grant, w_end, w_rf_adv;

  logic              r_rreq, r_rline, r_wreq, r_wline;
  logic [ADDR_W-1:0] r_raddr, r_waddr;
  logic [1:0]        r_rsize, r_wsize;
  logic [LINE_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;

  // A requester just served is ignored for one cycle while it drops its line.
  assign w_req = {bus.dc_uc_wreq_i, bus.dc_uc_rreq_i, bus.dc_ca_wreq_i,
                  bus.dc_ca_rreq_i, bus.ic_rreq_i} & ~r_mask;
  assign w_rf_req = {w_req[M_DCR], w_req[M_IC]};

`ifdef ARB_RR_EN
  mem_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_rf_req),
    .i_advance(w_rf_adv),
    .o_gnt    (w_rf_gnt)
  );
`else
  assign w_rf_gnt = w_rf_req[1] ? 2'b10 : {1'b0, w_rf_req[0]};
`endif

  // Next state: fixed priority grant from IDLE, completion on matching end.
  always_comb begin
    w_nxt = r_state;
    w_end = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if      (w_req[M_DCW]) w_nxt = ARB_DC_WB;
        else if (w_req[M_UW])  w_nxt = ARB_DC_UW;
        else if (w_req[M_UR])  w_nxt = ARB_DC_UR;
        else if (w_rf_gnt[1])  w_nxt = ARB_DC_RD;
        else if (w_rf_gnt[0])  w_nxt = ARB_IC_RD;
      end
      ARB_DC_WB, ARB_DC_UW: if (bus.br_wend_i) begin
        w_nxt = ARB_IDLE;
        w_end = 1'b1;
      end
      ARB_DC_UR, ARB_DC_RD, ARB_IC_RD: if (bus.br_rend_i) begin
        w_nxt = ARB_IDLE;
        w_end = 1'b1;
      end
      default: w_nxt = ARB_IDLE;
    endcase
  end

  assign w_grant  = (r_state == ARB_IDLE) && (w_nxt != ARB_IDLE);
  assign w_rf_adv = w_grant && ((w_nxt == ARB_DC_RD) || (w_nxt == ARB_IC_RD));

  // Owner of the current transaction, used to mask it after completion.
  always_comb begin
    w_own = '0;
    case (r_state)
      ARB_IC_RD: w_own[M_IC]  = 1'b1;
      ARB_DC_RD: w_own[M_DCR] = 1'b1;
      ARB_DC_WB: w_own[M_DCW] = 1'b1;
      ARB_DC_UR: w_own[M_UR]  = 1'b1;
      ARB_DC_UW: w_own[M_UW]  = 1'b1;
      default:   w_own = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_nxt;
  end

  // One-cycle mask of the requester that just completed.
  always_ff @(posedge clk) begin
    if (rst || !w_end) r_mask <= '0;
    else               r_mask <= w_own;
  end

  // Bridge command registers: loaded at grant, held until the end pulse.
  always_ff @(posedge clk) begin
    if (rst || w_end) begin
      r_rreq <= 1'b0; r_rline <= 1'b0; r_raddr <= '0; r_rsize <= '0;
      r_wreq <= 1'b0; r_wline <= 1'b0; r_waddr <= '0; r_wsize <= '0;
      r_wdata <= '0;  r_wstrb <= '0;
    end else if (w_grant) begin
      case (w_nxt)
        ARB_DC_WB: begin
          r_wreq  <= 1'b1; r_wline <= 1'b1; r_wsize <= LINE_SIZE;
          r_waddr <= {bus.dc_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_wdata <= bus.dc_line_i; r_wstrb <= 4'hF;
        end
        ARB_DC_UW: begin
          r_wreq  <= 1'b1; r_wline <= 1'b0; r_wsize <= bus.dc_size_i;
          r_waddr <= bus.dc_addr_i;
          r_wdata <= {{(LINE_W-32){1'b0}}, bus.dc_wdata_i};
          r_wstrb <= bus.dc_wen_i;
        end
        ARB_DC_UR: begin
          r_rreq  <= 1'b1; r_rline <= 1'b0; r_rsize <= bus.dc_size_i;
          r_raddr <= bus.dc_addr_i;
        end
        ARB_DC_RD: begin
          r_rreq  <= 1'b1; r_rline <= 1'b1; r_rsize <= LINE_SIZE;
          r_raddr <= {bus.dc_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        ARB_IC_RD: begin
          r_rreq  <= 1'b1; r_rline <= 1'b1; r_rsize <= LINE_SIZE;
          r_raddr <= {bus.ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign bus.br_rreq_o  = r_rreq;
  assign bus.br_rline_o = r_rline;
  assign bus.br_raddr_o = r_raddr;
  assign bus.br_rsize_o = r_rsize;
  assign bus.br_wreq_o  = r_wreq;
  assign bus.br_wline_o = r_wline;
  assign bus.br_waddr_o = r_waddr;
  assign bus.br_wdata_o = r_wdata;
  assign bus.br_wstrb_o = r_wstrb;
  assign bus.br_wsize_o = r_wsize;

  // End pulses are forwarded combinationally; suppressed in the reset cycle.
  assign bus.ic_rend_o = !rst && w_end && (r_state == ARB_IC_RD);
  assign bus.dc_rend_o = !rst && w_end && ((r_state == ARB_DC_RD) || (r_state == ARB_DC_UR));
  assign bus.dc_wend_o = !rst && w_end && ((r_state == ARB_DC_WB) || (r_state == ARB_DC_UW));
  assign bus.ic_line_o = bus.ic_rend_o ? bus.br_rdata_i : '0;
  assign bus.dc_line_o = !bus.dc_rend_o ? '0 :
                         (r_state == ARB_DC_UR) ? {{(LINE_W-32){1'b0}}, bus.br_rdata_i[31:0]} :
                         bus.br_rdata_i;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: stimulus pushes expected bridge
// commands and end pulses; a negedge monitor pops and compares them.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int LW = DEF_LINE_W;
  localparam int AW = DEF_ADDR_W;
  localparam int K_BRD = 0, K_BWR = 1, K_IEND = 2, K_DREND = 3, K_DWEND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_req_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  mem_req_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic        line;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [LW-1:0] data;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [LW-1:0] pat(input logic [31:0] seed);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = seed + i * 32'h0101_0101;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic ln, input logic [1:0] sz);
    exp_t e;
    e.kind = K_BRD; e.addr = a; e.line = ln; e.size = sz; e.strb = '0; e.data = '0;
    q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic ln, input logic [1:0] sz,
                         input logic [3:0] st, input logic [LW-1:0] d);
    exp_t e;
    e.kind = K_BWR; e.addr = a; e.line = ln; e.size = sz; e.strb = st; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_end(input int k, input logic [LW-1:0] d);
    exp_t e;
    e.kind = k; e.addr = '0; e.line = 1'b0; e.size = '0; e.strb = '0; e.data = d;
    q.push_back(e);
  endtask

  // Monitor: every DUT event pops one expectation.
  task automatic handle(input int k);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
      return;
    end
    e = q.pop_front();
    chk("event_kind", LW'(k), LW'(e.kind));
    case (k)
      K_BRD: begin
        chk("br_raddr", LW'(bus.br_raddr_o), LW'(e.addr));
        chk("br_rline", LW'(bus.br_rline_o), LW'(e.line));
        chk("br_rsize", LW'(bus.br_rsize_o), LW'(e.size));
      end
      K_BWR: begin
        chk("br_waddr", LW'(bus.br_waddr_o), LW'(e.addr));
        chk("br_wline", LW'(bus.br_wline_o), LW'(e.line));
        chk("br_wsize", LW'(bus.br_wsize_o), LW'(e.size));
        chk("br_wstrb", LW'(bus.br_wstrb_o), LW'(e.strb));
        chk("br_wdata", bus.br_wdata_o, e.data);
      end
      K_IEND:  chk("ic_line", bus.ic_line_o, e.data);
      K_DREND: chk("dc_line", bus.dc_line_o, e.data);
      default: ;
    endcase
  endtask

  logic p_r = 1'b0, p_w = 1'b0;
  always @(negedge clk) begin
    if (bus.ic_rend_o) handle(K_IEND);
    if (bus.dc_rend_o) handle(K_DREND);
    if (bus.dc_wend_o) handle(K_DWEND);
    if (bus.br_rreq_o && !p_r) handle(K_BRD);
    if (bus.br_wreq_o && !p_w) handle(K_BWR);
    p_r = bus.br_rreq_o;
    p_w = bus.br_wreq_o;
  end

  // Requests must stay high while their refill is in flight.
  always @(negedge clk)
    if (!rst) assert (!(dut.r_state == ARB_IC_RD && !bus.ic_rreq_i))
      else $error("ic_rreq dropped while granted");

  // Bridge model: end pulse after a programmed latency, plus one-shot strays.
  int rd_lat = 5, wr_lat = 3, rcnt = 0, wcnt = 0;
  logic [LW-1:0] rd_src = '0;
  bit stray_r = 1'b0, stray_w = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.br_rend_i = 1'b0;
    bus.br_wend_i = 1'b0;
    if (bus.br_rreq_o) begin
      if (rcnt == rd_lat) begin bus.br_rend_i = 1'b1; bus.br_rdata_i = rd_src; rcnt = 0; end
      else rcnt++;
    end else rcnt = 0;
    if (bus.br_wreq_o) begin
      if (wcnt == wr_lat) begin bus.br_wend_i = 1'b1; wcnt = 0; end
      else wcnt++;
    end else wcnt = 0;
    if (stray_r) begin bus.br_rend_i = 1'b1; bus.br_rdata_i = rd_src; stray_r = 1'b0; end
    if (stray_w) begin bus.br_wend_i = 1'b1; stray_w = 1'b0; end
  end

  // Wait until at most 'left' expectations remain, then step past the edge.
  task automatic wait_q(input int left, input int budget, input string nm);
    int n = 0;
    do begin @(posedge clk); n++; end while (q.size() > left && n < budget);
    if (q.size() > left) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_%s: got %0d pending expected %0d", nm, q.size(), left);
      q.delete();
    end
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, LW'({bus.br_rreq_o, bus.br_rline_o, bus.br_rsize_o, bus.br_wreq_o,
                           bus.br_wline_o, bus.br_wstrb_o, bus.br_wsize_o, bus.ic_rend_o,
                           bus.dc_rend_o, bus.dc_wend_o}), '0);
    chk({nm, "_addr"}, LW'({bus.br_raddr_o, bus.br_waddr_o}), '0);
    chk({nm, "_wdata"}, bus.br_wdata_o, '0);
    chk({nm, "_lines"}, bus.ic_line_o | bus.dc_line_o, '0);
  endtask

  initial begin
    bit ic_first;
    int n;
    bus.ic_rreq_i = 0; bus.ic_addr_i = '0;
    bus.dc_ca_rreq_i = 0; bus.dc_ca_wreq_i = 0; bus.dc_uc_rreq_i = 0; bus.dc_uc_wreq_i = 0;
    bus.dc_addr_i = '0; bus.dc_wen_i = '0; bus.dc_wdata_i = '0; bus.dc_size_i = '0;
    bus.dc_line_i = '0; bus.br_rend_i = 0; bus.br_rdata_i = '0; bus.br_wend_i = 0;
`ifdef ARB_RR_EN
    ic_first = 1'b1;
`else
    ic_first = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;

    // icache refill: aligned line address, one end pulse with data
    rd_lat = 5; rd_src = pat(32'h1C00_0000);
    push_rd(32'h1FC0_0000, 1'b1, LINE_SIZE);
    push_end(K_IEND, pat(32'h1C00_0000));
    bus.ic_addr_i = 32'h1FC0_0014; bus.ic_rreq_i = 1;
    wait_q(0, 40, "ic_refill"); bus.ic_rreq_i = 0;

    // writeback and refill together: writeback first, refill right after
    wr_lat = 3; rd_src = pat(32'h2000_0000);
    bus.dc_addr_i = 32'h0000_1040; bus.dc_line_i = pat(32'hD000_0000);
    push_wr(32'h0000_1040, 1'b1, LINE_SIZE, 4'hF, pat(32'hD000_0000));
    push_end(K_DWEND, '0);
    push_rd(32'h0000_1040, 1'b1, LINE_SIZE);
    push_end(K_DREND, pat(32'h2000_0000));
    bus.dc_ca_wreq_i = 1; bus.dc_ca_rreq_i = 1;
    wait_q(2, 40, "writeback"); bus.dc_ca_wreq_i = 0;
    wait_q(0, 40, "dc_refill"); bus.dc_ca_rreq_i = 0;

    // uncached write: single word, strobes and size passed through
    bus.dc_addr_i = 32'hBFAF_F000; bus.dc_wen_i = 4'b0011; bus.dc_size_i = 2'd1;
    bus.dc_wdata_i = 32'h1234_5678;
    push_wr(32'hBFAF_F000, 1'b0, 2'd1, 4'b0011, LW'(32'h1234_5678));
    push_end(K_DWEND, '0);
    bus.dc_uc_wreq_i = 1;
    wait_q(0, 40, "uc_write"); bus.dc_uc_wreq_i = 0;

    // uncached read: unaligned address kept, word returned in [31:0]
    rd_lat = 2; rd_src = pat(32'h3000_0000);
    bus.dc_addr_i = 32'hBFAF_F00C; bus.dc_size_i = 2'd2;
    push_rd(32'hBFAF_F00C, 1'b0, 2'd2);
    push_end(K_DREND, LW'(32'h3000_0000));
    bus.dc_uc_rreq_i = 1;
    wait_q(0, 40, "uc_read"); bus.dc_uc_rreq_i = 0;

    // uncached write beats uncached read
    rd_src = pat(32'h4000_0000);
    bus.dc_addr_i = 32'hBFAF_F104; bus.dc_wen_i = 4'hF; bus.dc_wdata_i = 32'hDEAD_BEEF;
    push_wr(32'hBFAF_F104, 1'b0, 2'd2, 4'hF, LW'(32'hDEAD_BEEF));
    push_end(K_DWEND, '0);
    push_rd(32'hBFAF_F104, 1'b0, 2'd2);
    push_end(K_DREND, LW'(32'h4000_0000));
    bus.dc_uc_wreq_i = 1; bus.dc_uc_rreq_i = 1;
    wait_q(2, 40, "uc_prio_w"); bus.dc_uc_wreq_i = 0;
    wait_q(0, 40, "uc_prio_r"); bus.dc_uc_rreq_i = 0;

    // icache and dcache refills held for four grants
    repeat (2) @(posedge clk); #1;
    rd_src = pat(32'h5000_0000);
    bus.ic_addr_i = 32'h2000_0010; bus.dc_addr_i = 32'h0000_3018;
    for (int i = 0; i < 4; i++) begin
      bit ic_turn;
      ic_turn = ((i % 2) == 0) ? ic_first : !ic_first;
      push_rd(ic_turn ? 32'h2000_0000 : 32'h0000_3000, 1'b1, LINE_SIZE);
      push_end(ic_turn ? K_IEND : K_DREND, pat(32'h5000_0000));
    end
    bus.ic_rreq_i = 1; bus.dc_ca_rreq_i = 1;
    wait_q(0, 200, "refill_x4"); bus.ic_rreq_i = 0; bus.dc_ca_rreq_i = 0;

    // simultaneous refill requests from a clean IDLE
    repeat (2) @(posedge clk); #1;
    push_rd(ic_first ? 32'h2000_0000 : 32'h0000_3000, 1'b1, LINE_SIZE);
    push_end(ic_first ? K_IEND : K_DREND, pat(32'h5000_0000));
    bus.ic_rreq_i = 1; bus.dc_ca_rreq_i = 1;
    wait_q(0, 40, "refill_tie"); bus.ic_rreq_i = 0; bus.dc_ca_rreq_i = 0;

    // stray write end in IDLE, stray read end in DC_WB: both ignored
    stray_w = 1'b1;
    repeat (3) @(posedge clk); #1;
    wr_lat = 8;
    bus.dc_addr_i = 32'h0000_4004; bus.dc_line_i = pat(32'h7000_0000);
    push_wr(32'h0000_4000, 1'b1, LINE_SIZE, 4'hF, pat(32'h7000_0000));
    push_end(K_DWEND, '0);
    bus.dc_ca_wreq_i = 1;
    n = 0;
    while (!bus.br_wreq_o && n < 10) begin @(posedge clk); #1; n++; end
    stray_r = 1'b1;
    wait_q(0, 40, "stray_wb"); bus.dc_ca_wreq_i = 0;

    // reset in the middle of an icache refill, with an end in the reset cycle
    rd_lat = 20;
    bus.ic_addr_i = 32'h5000_0000;
    push_rd(32'h5000_0000, 1'b1, LINE_SIZE);
    bus.ic_rreq_i = 1;
    n = 0;
    while (!bus.br_rreq_o && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    stray_r = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; bus.ic_rreq_i = 0;
    @(negedge clk);
    chk_quiet("after_rst");
    chk("queue_after_rst", LW'(q.size()), '0);

    repeat (4) @(posedge clk);
    chk("queue_drained", LW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
